// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared two-wire serial bus, with a guard gap
// between tenancies and a hold-time watchdog that masks a stuck requester.
`timescale 1ns/1ps
module serial_bus_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 1024,
    parameter int GAP      = 2,
    parameter int CW       = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   fault_clr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic [N-1:0]   fault,
    output logic           timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           busy_q, busy_d;
    logic [N-1:0]   fault_q, fault_d;
    logic           timeout_q, timeout_d;

    logic [N-1:0]   elig;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   fault_set;
    logic [IDW-1:0] ptr_next;
    int unsigned    j;

    assign elig     = req & ~fault_q;
    assign ptr_next = (owner_q == IDW'(N-1)) ? '0 : owner_q + 1'b1;

    // Wrap-around scan starting at the round-robin pointer; never yields an index >= N.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!pick_found && elig[j[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = j[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        fault_set = '0;
        case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_found) begin
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + 1'b1;
                // A release sampled on the final hold cycle takes priority over revocation.
                if (!req[owner_q] || cnt_q == CW'(MAX_HOLD-1)) begin
                    if (req[owner_q]) begin
                        fault_set[owner_q] = 1'b1;
                        timeout_d          = 1'b1;
                    end
                    gnt_d   = '0;
                    busy_d  = 1'b1;
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                gnt_d  = '0;
                busy_d = 1'b1;
                if (cnt_q == CW'(GAP-1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        fault_d = (fault_q & ~fault_clr) | fault_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            fault_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign fault   = fault_q;
    assign timeout = timeout_q;

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Shares the two-wire fast serial bus (port line + data line) among up to N core communication units.
- Each unit raises its access request; this block returns a one-hot access grant.
- Round-robin fairness; a guard gap between tenancies lets the bus return to idle.
- Hold-time watchdog revokes a stuck grant and masks the faulty requester until software clears it.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, width of owner index, equal to ceil(log2(N))
MAX_HOLD, 1024, maximum cycles a grant may be held before forced revocation (>=2)
GAP, 2, idle cycles between tenancies (>=1)
CW, 11, hold/gap counter width; must hold MAX_HOLD

Ports:
clk  input  1  bus clock (same clock as the serial bus engines)
rst  input  1  asynchronous active-high reset
req  input  N  access request per requester, level, held for whole transfer
fault_clr  input  N  per-requester fault clear, single-cycle pulse
gnt  output  N  one-hot access grant, registered
owner  output  IDW  index of current/last grantee, registered
busy  output  1  high in GRANT and GAP states
fault  output  N  sticky per-requester watchdog fault; faulted requester is masked
timeout  output  1  single-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, owner=0, busy=0, fault=0, timeout=0.
  - State IDLE, round-robin pointer ptr=0, counter=0.
- All outputs are registered. gnt is never more than one-hot.
- Eligibility: elig = req & ~fault.
- IDLE:
  - If elig != 0, pick the first set bit scanning ptr, ptr+1, ..., N-1, 0, ... (wrap).
  - Next edge: gnt[idx]=1, owner=idx, busy=1, counter=0, state GRANT.
  - Latency: req high at edge k produces gnt high after edge k (1 cycle).
  - A req dropped before being sampled gets no grant.
- GRANT:
  - counter increments each cycle.
  - If req[owner] is sampled low: next edge gnt=0, ptr=(owner+1) mod N, counter=0, state GAP.
  - Else if counter==MAX_HOLD-1: next edge gnt=0, fault[owner]=1, timeout=1 for one cycle, ptr=(owner+1) mod N, counter=0, state GAP.
  - Release wins over timeout on the same edge: no fault is set.
  - Requests from other units are ignored until return to IDLE.
  - fault_clr of the owner during GRANT has no effect on the grant.
- GAP:
  - gnt=0, busy=1; counter counts to GAP-1.
  - Then state IDLE, busy=0.
  - A new grant is possible on the edge after IDLE is entered.
  - Minimum spacing from gnt falling to the next gnt rising is GAP+1 cycles.
- owner holds its last value outside GRANT.
- fault_clr[i] clears fault[i] on the next edge in any state. If a set and clear of the same bit coincide, set wins.
- N not a power of two: ptr wraps from N-1 to 0; index values >= N never appear.
- Reset mid-GRANT: gnt drops immediately (asynchronously); no fault is recorded.

Test Plan:
- Single requester: req=0001 at cycle 3 → gnt=0001, owner=0, busy=1 from cycle 4. Drop req at cycle 10 → gnt=0 at cycle 11; busy=0 at cycle 13 (GAP=2).
- Round robin: req=1111 held; each owner releases after 5 cycles then re-requests → grant order 0,1,2,3,0; gnt never two-hot; spacing gnt-fall to next gnt-rise = 3 cycles.
- Priority from pointer: after owner 2 releases, req=0101 → grant goes to 0 (scan 3,0), not 2.
- Watchdog: MAX_HOLD=8, req[1] stuck high → gnt[1] falls after 8 grant cycles; timeout pulses once; fault=0010. Further req[1] is ignored. fault_clr=0010 → fault=0, then req[1] is granted again.
- Coincident release and timeout at counter==MAX_HOLD-1 → gnt drops, fault stays 0, timeout stays 0.
- rst pulsed while gnt=0100 → gnt=0 immediately. After release, req=0100 → grant goes to 2 via scan from ptr=0 (bits 0,1 idle), owner=2.
